// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD instruction-side blocks.
// Provides the instruction-memory FSM state type, default field widths,
// the STOP opcode and a helper that builds the padded STOP instruction.
package simd_pkg;

  localparam int unsigned DEF_OPCODE_LEN  = 4;
  localparam int unsigned DEF_PC_WIDTH    = 12;
  localparam int unsigned DEF_INSTR_WIDTH = 16;

  localparam logic [DEF_OPCODE_LEN-1:0] DEF_STOP_OPCODE = 4'h8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } imem_state_t;

  // STOP opcode in the low field, zeros above.
  function automatic logic [DEF_INSTR_WIDTH-1:0] stop_word(
    input logic [DEF_OPCODE_LEN-1:0] op
  );
    return {{(DEF_INSTR_WIDTH - DEF_OPCODE_LEN){1'b0}}, op};
  endfunction

endpackage

// File: rtl/instr_mem_server_if.sv
// Bus bundle for instr_mem_server.
// Carries the host load stream (load_valid/ready/data/last), the PC-side
// fetch path (pc in, instruction/opcode out, start_valid pulse) and run
// status (run_active, run_done, load_overflow).
//   master : host loader + program counter side
//   slave  : instr_mem_server
interface instr_mem_server_if
  import simd_pkg::*;
#(
  parameter int unsigned OPCODE_LEN  = DEF_OPCODE_LEN,
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
) ();

  logic                   load_valid;
  logic                   load_ready;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;
  logic                   start_valid;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [OPCODE_LEN-1:0]  opcode;
  logic                   run_active;
  logic                   run_done;
  logic                   load_overflow;

  modport master (
    output load_valid, load_data, load_last, pc,
    input  load_ready, start_valid, instruction, opcode,
           run_active, run_done, load_overflow
  );

  modport slave (
    input  load_valid, load_data, load_last, pc,
    output load_ready, start_valid, instruction, opcode,
           run_active, run_done, load_overflow
  );

endinterface

// File: rtl/instr_ram.sv
// Instruction storage: DEPTH x DATA_WIDTH, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module instr_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-side responder for the SIMD program counter.
// Accepts a program image over a valid/ready load stream, pulses
// start_valid for one cycle, then serves the word at pc combinationally
// every cycle until the STOP opcode is fetched.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : instr_mem_server_if.slave (load stream, fetch path, status)
module instr_mem_server
  import simd_pkg::*;
#(
  parameter int unsigned OPCODE_LEN  = DEF_OPCODE_LEN,
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned DEPTH       = 2 ** PC_WIDTH,
  parameter logic [OPCODE_LEN-1:0] STOP_OPCODE = DEF_STOP_OPCODE
) (
  input logic              clk,
  input logic              rst,
  instr_mem_server_if.slave bus
);

  localparam logic [INSTR_WIDTH-1:0] STOP_WORD = INSTR_WIDTH'(stop_word(STOP_OPCODE));

  imem_state_t          r_state;
  logic [PC_WIDTH-1:0]  r_wr_ptr;
  logic [PC_WIDTH:0]    r_load_count;   // one extra bit so a full image counts DEPTH
  logic                 r_load_ready;
  logic                 r_start_valid;
  logic                 r_run_active;
  logic                 r_load_overflow;

  logic                   w_accept;
  logic                   w_at_end;
  logic                   w_finish;
  logic                   w_stop_hit;
  logic [INSTR_WIDTH-1:0] w_ram_rdata;
  logic [INSTR_WIDTH-1:0] w_instr;

  assign w_accept = bus.load_valid && r_load_ready;
  assign w_at_end = (r_wr_ptr == PC_WIDTH'(DEPTH - 1));
  // A beat filling the last slot ends the load even without load_last.
  assign w_finish = w_accept && (bus.load_last || w_at_end);

  instr_ram #(
    .ADDR_WIDTH (PC_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.load_data),
    .i_raddr (bus.pc),
    .o_rdata (w_ram_rdata)
  );

  // Addresses beyond the loaded image read as STOP so a run always ends.
  always_comb begin
    w_instr = '0;
    if (r_state == RUN) begin
      if ({1'b0, bus.pc} < r_load_count) begin
        w_instr = w_ram_rdata;
      end else begin
        w_instr = STOP_WORD;
      end
    end
  end

  assign w_stop_hit = (r_state == RUN) && (w_instr[OPCODE_LEN-1:0] == STOP_OPCODE);

  // IDLE and LOAD accept beats identically; wr_ptr is already 0 in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_wr_ptr        <= '0;
      r_load_count    <= '0;
      r_load_ready    <= 1'b1;
      r_start_valid   <= 1'b0;
      r_run_active    <= 1'b0;
      r_load_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PC_WIDTH'(1);
            if (w_finish) begin
              r_load_count  <= {1'b0, r_wr_ptr} + (PC_WIDTH + 1)'(1);
              r_state       <= START;
              r_load_ready  <= 1'b0;
              r_start_valid <= 1'b1;
              if (!bus.load_last) begin
                r_load_overflow <= 1'b1;
              end
            end else begin
              r_state <= LOAD;
            end
          end
        end
        START: begin
          r_start_valid <= 1'b0;
          r_run_active  <= 1'b1;
          r_state       <= RUN;
        end
        RUN: begin
          if (w_stop_hit) begin
            r_state      <= IDLE;
            r_run_active <= 1'b0;
            r_load_ready <= 1'b1;
            r_wr_ptr     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready    = r_load_ready;
  assign bus.start_valid   = r_start_valid;
  assign bus.run_active    = r_run_active;
  assign bus.load_overflow = r_load_overflow;
  assign bus.run_done      = w_stop_hit;
  assign bus.instruction   = w_instr;
  assign bus.opcode        = w_instr[OPCODE_LEN-1:0];

endmodule
